// File: rtl/alignement_marker_lock_lane_rx.sv
// Per-lane receive alignment-marker lock with BIP3/BIP7 check.
// Blocks pass through with one cycle of latency, flagged when they are an accepted marker.
module alignement_marker_lock_lane_rx #(
    parameter int          HEAD_W   = 2,
    parameter int          DATA_W   = 64,
    parameter logic [63:0] LANE_ENC = 64'h00b8896f00477690,
    parameter int          AM_GAP   = 16384,
    parameter int          INV_MAX  = 4,
    parameter int          ERR_W    = 16,
    localparam int         BLOCK_W  = HEAD_W + DATA_W
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               block_lock,
    input  logic               data_v_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic               data_v_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               am_v_o,
    output logic               am_lock_o,
    output logic               bip_err_o,
    output logic [ERR_W-1:0]   bip_err_cnt_o
);
    localparam int CNT_W = $clog2(AM_GAP);
    localparam int INV_W = $clog2(INV_MAX + 1);

    typedef enum logic [1:0] {FIND, VERIFY, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INV_W-1:0]   inv_q, inv_d;
    logic [7:0]         acc_q, acc_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               data_v_q, am_v_q, bip_err_q;
    logic [BLOCK_W-1:0] data_q;

    logic       match, at_pos, am_hit, bip_bad;
    logic [7:0] bip_blk, rx_bip3, rx_bip7;

    // Payload byte i sits at data_i[8i+9:8i+2]; bytes 3 and 7 carry BIP3/BIP7.
    assign match = (data_i[1:0] == 2'b10)
                && (data_i[9:2]   == LANE_ENC[7:0])
                && (data_i[17:10] == LANE_ENC[15:8])
                && (data_i[25:18] == LANE_ENC[23:16])
                && (data_i[41:34] == LANE_ENC[39:32])
                && (data_i[49:42] == LANE_ENC[47:40])
                && (data_i[57:50] == LANE_ENC[55:48]);
    assign rx_bip3 = data_i[33:26];
    assign rx_bip7 = data_i[65:58];
    assign at_pos  = (cnt_q == CNT_W'(AM_GAP - 1));

    // BIP bit gi covers bit gi of every payload byte; the two header bits fold into bits 3 and 4.
    genvar gi, gk;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bip
            logic [7:0] taps;
            for (gk = 0; gk < 8; gk++) begin : g_tap
                assign taps[gk] = data_i[gi + 2 + 8*gk];
            end
            if (gi == 3) begin : g_h0
                assign bip_blk[gi] = (^taps) ^ data_i[0];
            end else if (gi == 4) begin : g_h1
                assign bip_blk[gi] = (^taps) ^ data_i[1];
            end else begin : g_plain
                assign bip_blk[gi] = ^taps;
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        acc_d   = acc_q;
        am_hit  = 1'b0;
        if (!block_lock) begin
            state_d = FIND;
            cnt_d   = '0;
            inv_d   = '0;
        end else if (data_v_i) begin
            if (state_q == FIND) begin
                if (match) begin
                    state_d = VERIFY;
                    cnt_d   = '0;
                    inv_d   = '0;
                    acc_d   = '0;
                end
            end else if (at_pos) begin
                cnt_d = '0;
                acc_d = '0;
                if (match) begin
                    am_hit  = 1'b1;
                    state_d = LOCKED;
                    inv_d   = '0;
                end else if (state_q == VERIFY) begin
                    state_d = FIND;
                end else if (inv_q == INV_W'(INV_MAX - 1)) begin
                    state_d = FIND;
                    inv_d   = '0;
                end else begin
                    inv_d = inv_q + INV_W'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = acc_q ^ bip_blk;
            end
        end
    end

    assign bip_bad   = am_hit && ((rx_bip3 != acc_q) || (rx_bip7 != ~acc_q));
    assign err_cnt_d = (bip_bad && !(&err_cnt_q)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= FIND;
            cnt_q     <= '0;
            inv_q     <= '0;
            acc_q     <= '0;
            err_cnt_q <= '0;
            data_v_q  <= 1'b0;
            data_q    <= '0;
            am_v_q    <= 1'b0;
            bip_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inv_q     <= inv_d;
            acc_q     <= acc_d;
            err_cnt_q <= err_cnt_d;
            data_v_q  <= data_v_i;
            am_v_q    <= am_hit;
            bip_err_q <= bip_bad;
            if (data_v_i) begin
                data_q <= data_i;
            end
        end
    end

    assign data_v_o      = data_v_q;
    assign data_o        = data_q;
    assign am_v_o        = am_v_q;
    assign bip_err_o     = bip_err_q;
    assign bip_err_cnt_o = err_cnt_q;
    assign am_lock_o     = (state_q == LOCKED);

endmodule

// File: tb/tb_alignement_marker_lock_lane_rx.sv
// Directed bench for the lane AM lock / BIP checker with a 16-block marker period.
module tb_alignement_marker_lock_lane_rx;
    localparam logic [63:0] ENC = 64'h00b8896f00477690;
    localparam int GAP   = 16;
    localparam int ERR_W = 4;

    logic             clk = 1'b0;
    logic             nreset = 1'b0;
    logic             block_lock = 1'b0;
    logic             data_v_i = 1'b0;
    logic [65:0]      data_i = '0;
    logic             data_v_o, am_v_o, am_lock_o, bip_err_o;
    logic [65:0]      data_o;
    logic [ERR_W-1:0] bip_err_cnt_o;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] tb_acc = '0;
    logic [65:0] last_d = '0;

    alignement_marker_lock_lane_rx #(
        .LANE_ENC(ENC), .AM_GAP(GAP), .INV_MAX(4), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .nreset(nreset), .block_lock(block_lock),
        .data_v_i(data_v_i), .data_i(data_i),
        .data_v_o(data_v_o), .data_o(data_o), .am_v_o(am_v_o),
        .am_lock_o(am_lock_o), .bip_err_o(bip_err_o), .bip_err_cnt_o(bip_err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit p of the block lands on BIP lane bit p-2 mod 8; header bits go to lanes 3 and 4.
    function automatic logic [7:0] bip_of(input logic [65:0] d);
        logic [7:0] r = '0;
        for (int p = 0; p < 66; p++) begin
            int lane = (p < 2) ? p + 3 : (p - 2) % 8;
            r[lane] = r[lane] ^ d[p];
        end
        return r;
    endfunction

    function automatic logic [65:0] make_am(input logic [7:0] b3, input logic [7:0] b7,
                                            input logic bad0);
        logic [63:0] enc = ENC;
        logic [65:0] d;
        d[1:0] = 2'b10;
        for (int i = 0; i < 8; i++) d[8*i+2 +: 8] = enc[8*i +: 8];
        d[33:26] = b3;
        d[65:58] = b7;
        if (bad0) d[9:2] = d[9:2] ^ 8'hff;
        return d;
    endfunction

    task automatic step(input logic v, input logic [65:0] d);
        data_v_i = v;
        data_i   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic flip);
        logic [65:0] d = {$urandom(), $urandom(), 2'b01};
        tb_acc = tb_acc ^ bip_of(d);
        if (flip) d[2] = ~d[2];
        last_d = d;
        step(1'b1, d);
    endtask

    task automatic send_gap(input int n);
        for (int i = 0; i < n; i++) send_data(1'b0);
    endtask

    task automatic send_am(input logic bad0, input logic bad_bip);
        logic [65:0] d = make_am(bad_bip ? (tb_acc ^ 8'h01) : tb_acc, ~tb_acc, bad0);
        last_d = d;
        step(1'b1, d);
        tb_acc = '0;
    endtask

    initial begin
        #12;
        check("rst_lock", am_lock_o, 0);
        check("rst_dv", data_v_o, 0);
        check("rst_cnt", bip_err_cnt_o, 0);
        check("rst_data", data_o, 0);
        @(posedge clk); #1;
        nreset = 1'b1;
        block_lock = 1'b1;

        // 1: initial lock
        send_gap(3);
        send_am(0, 0);
        check("t1_am1_v", am_v_o, 0);
        check("t1_am1_lock", am_lock_o, 0);
        send_gap(GAP - 1);
        check("t1_prelock", am_lock_o, 0);
        send_am(0, 0);
        check("t1_am2_v", am_v_o, 1);
        check("t1_am2_lock", am_lock_o, 1);
        check("t1_am2_data", data_o, last_d);
        check("t1_am2_berr", bip_err_o, 0);
        send_gap(GAP - 1);
        check("t1_data_nov", am_v_o, 0);
        send_am(0, 0);
        check("t1_am3_v", am_v_o, 1);
        check("t1_cnt", bip_err_cnt_o, 0);

        // 2: single bit error in one data block
        send_gap(5);
        send_data(1'b1);
        send_gap(GAP - 7);
        send_am(0, 0);
        check("t2_berr", bip_err_o, 1);
        check("t2_cnt", bip_err_cnt_o, 1);
        check("t2_lock", am_lock_o, 1);
        send_gap(1);
        check("t2_pulse_end", bip_err_o, 0);
        send_gap(GAP - 2);
        send_am(0, 0);
        check("t2_clean", bip_err_o, 0);

        // 3: bad markers
        for (int i = 0; i < 3; i++) begin
            send_gap(GAP - 1);
            send_am(1, 0);
            check($sformatf("t3_bad%0d_v", i), am_v_o, 0);
            check($sformatf("t3_bad%0d_lock", i), am_lock_o, 1);
        end
        send_gap(GAP - 1);
        send_am(0, 0);
        check("t3_good_v", am_v_o, 1);
        for (int i = 0; i < 4; i++) begin
            send_gap(GAP - 1);
            send_am(1, 0);
            check($sformatf("t3_drop%0d_lock", i), am_lock_o, (i < 3) ? 1'b1 : 1'b0);
        end

        // 4: second marker at the wrong position
        send_gap(3);
        send_am(0, 0);
        send_gap(GAP - 2);
        send_am(0, 0);
        check("t4_shift_v", am_v_o, 0);
        send_gap(1);
        check("t4_lock0", am_lock_o, 0);
        send_am(0, 0);
        send_gap(GAP - 1);
        send_am(0, 0);
        check("t4_relock", am_lock_o, 1);
        check("t4_relock_v", am_v_o, 1);

        // 5: 50% valid
        for (int a = 0; a < 2; a++) begin
            for (int i = 0; i < GAP - 1; i++) begin
                send_data(1'b0);
                step(1'b0, {$urandom(), $urandom(), 2'b10});
                if (i == 4) begin
                    check("t5_hold", data_o, last_d);
                    check("t5_dv0", data_v_o, 0);
                end
            end
            send_am(0, 0);
            check($sformatf("t5_am%0d_v", a), am_v_o, 1);
            check($sformatf("t5_am%0d_berr", a), bip_err_o, 0);
        end
        check("t5_cnt", bip_err_cnt_o, 1);

        // 6: block_lock drop, reset, saturation
        send_gap(5);
        block_lock = 1'b0;
        send_data(1'b0);
        block_lock = 1'b1;
        check("t6_bl_lock", am_lock_o, 0);
        check("t6_bl_cnt", bip_err_cnt_o, 1);
        send_gap(2);
        send_am(0, 0);
        send_gap(GAP - 1);
        send_am(0, 0);
        check("t6_bl_relock", am_lock_o, 1);
        send_gap(6);
        nreset = 1'b0;
        #2;
        check("t6_rst_lock", am_lock_o, 0);
        check("t6_rst_cnt", bip_err_cnt_o, 0);
        check("t6_rst_dv", data_v_o, 0);
        @(posedge clk); #1;
        nreset = 1'b1;
        send_gap(2);
        send_am(0, 0);
        send_gap(GAP - 1);
        send_am(0, 0);
        check("t6_rst_relock", am_lock_o, 1);
        for (int i = 1; i <= (1 << ERR_W) + 3; i++) begin
            send_gap(GAP - 1);
            send_am(0, 1);
            if (i == (1 << ERR_W) - 1) check("t6_cnt_max", bip_err_cnt_o, 15);
        end
        check("t6_sat", bip_err_cnt_o, 15);
        check("t6_sat_pulse", bip_err_o, 1);
        check("t6_sat_lock", am_lock_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
